// File: rtl/dance_pkg.sv
// Shared definitions for the dance game scoring path: 7-seg glyphs, hit classes, default points.
// Latency: n/a (package only).
// Backpressure: n/a.
package dance_pkg;

  // Judged hit class after edge detection and priority resolution
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    GOOD    = 2'd1,
    PERFECT = 2'd2,
    MISS    = 2'd3
  } hit_e;

  // Defaults shared with the pattern generator and the judge
  localparam int DEF_PERFECT_PTS = 3;
  localparam int DEF_GOOD_PTS    = 1;
  localparam int DEF_COMBO_STEP  = 10;
  localparam int DEF_MAX_MULT    = 4;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low 7-seg glyph, segment order gfedcba; non-BCD codes blank the digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_counter_sat.sv
// Saturating multi-digit BCD up-counter; stops at all-9s and flags it.
// Latency: increment visible one clock after inc_i; at_max_o is combinational from the count.
// Backpressure: none; inc_i is ignored once saturated.
module bcd_counter_sat #(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  inc_i,
  output logic [DIGITS*4-1:0]   bcd_o,
  output logic                  at_max_o
);

  logic [DIGITS*4-1:0] cnt_q, cnt_d;
  logic                carry;

  // Saturation flag: every digit is 9
  always_comb begin
    at_max_o = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (cnt_q[d*4 +: 4] != 4'd9) at_max_o = 1'b0;
    end
  end

  // Ripple the +1 through all digits within the cycle
  always_comb begin
    cnt_d = cnt_q;
    carry = inc_i & ~at_max_o;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (cnt_q[d*4 +: 4] == 4'd9) begin
          cnt_d[d*4 +: 4] = 4'd0;
        end else begin
          cnt_d[d*4 +: 4] = cnt_q[d*4 +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  // Count register; clear wins over increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign bcd_o = cnt_q;

endmodule

// File: rtl/dance_score_engine.sv
// Per-player hit grading, combo/multiplier tracking and pending-point drain into BCD scores.
// Latency: hit at edge n loads pending at edge n, score +1 per cycle from edge n+1; seg lags score by 1.
// Backpressure: none; pending saturates at 255 and is dropped once the score is all-9s.
module dance_score_engine
  import dance_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int DIGITS      = 2,
  parameter int PERFECT_PTS = DEF_PERFECT_PTS,
  parameter int GOOD_PTS    = DEF_GOOD_PTS,
  parameter int COMBO_STEP  = DEF_COMBO_STEP,
  parameter int MAX_MULT    = DEF_MAX_MULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          game_active_i,
  input  logic                          clear_i,
  input  logic [N_PLAYERS-1:0]          hit_perfect_i,
  input  logic [N_PLAYERS-1:0]          hit_good_i,
  input  logic [N_PLAYERS-1:0]          hit_miss_i,
  output logic [N_PLAYERS*DIGITS*4-1:0] score_bcd_o,
  output logic [N_PLAYERS*DIGITS*7-1:0] seg_out_o,
  output logic [N_PLAYERS*8-1:0]        combo_o,
  output logic [N_PLAYERS*3-1:0]        mult_o,
  output logic [N_PLAYERS-1:0]          busy_o,
  output logic [N_PLAYERS-1:0]          saturated_o
);

  localparam int STEP_W = (COMBO_STEP > 1) ? $clog2(COMBO_STEP) : 1;

  logic [N_PLAYERS-1:0] prev_perfect_q, prev_good_q, prev_miss_q;
  logic [N_PLAYERS-1:0] ev_perfect, ev_good, ev_miss;

  assign ev_perfect = hit_perfect_i & ~prev_perfect_q;
  assign ev_good    = hit_good_i    & ~prev_good_q;
  assign ev_miss    = hit_miss_i    & ~prev_miss_q;

  // Edge history tracks the inputs every cycle, even while the game is paused
  always_ff @(posedge clock or posedge reset) begin
    if (reset || clear_i) begin
      prev_perfect_q <= '0;
      prev_good_q    <= '0;
      prev_miss_q    <= '0;
    end else begin
      prev_perfect_q <= hit_perfect_i;
      prev_good_q    <= hit_good_i;
      prev_miss_q    <= hit_miss_i;
    end
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    hit_e                hit;
    logic [7:0]          combo_q, combo_d, pend_q, pend_d, pts;
    logic [2:0]          mult_q, mult_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [8:0]          sum;
    logic                drain, at_max;
    logic [DIGITS*4-1:0] bcd;
    logic [DIGITS*7-1:0] seg_q, seg_d;

    // Resolve same-cycle events: miss beats perfect beats good; nothing counts while paused
    always_comb begin
      hit = NONE;
      if (game_active_i) begin
        if (ev_miss[p])         hit = MISS;
        else if (ev_perfect[p]) hit = PERFECT;
        else if (ev_good[p])    hit = GOOD;
      end
    end

    // Combo, multiplier step and pending-point bookkeeping
    always_comb begin
      combo_d = combo_q;
      mult_d  = mult_q;
      step_d  = step_q;
      pts     = 8'd0;
      if (hit == MISS) begin
        combo_d = 8'd0;
        mult_d  = 3'd1;
        step_d  = '0;
      end else if (hit != NONE) begin
        // Points use the multiplier in force before this hit
        pts = ((hit == PERFECT) ? 8'(PERFECT_PTS) : 8'(GOOD_PTS)) * {5'd0, mult_q};
        if (combo_q != 8'hFF) combo_d = combo_q + 8'd1;
        if (step_q == STEP_W'(COMBO_STEP - 1)) begin
          step_d = '0;
          if (mult_q < 3'(MAX_MULT)) mult_d = mult_q + 3'd1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      drain  = (pend_q != 8'd0) && !at_max;
      sum    = {1'b0, pend_q} + {1'b0, pts} - {8'd0, drain};
      if (at_max)            pend_d = 8'd0;
      else if (sum[8])       pend_d = 8'hFF;
      else                   pend_d = sum[7:0];
      for (int d = 0; d < DIGITS; d++) seg_d[d*7 +: 7] = seg7(bcd[d*4 +: 4]);
    end

    // Player state registers; clear returns everything to the reset picture
    always_ff @(posedge clock or posedge reset) begin
      if (reset || clear_i) begin
        combo_q <= 8'd0;
        mult_q  <= 3'd1;
        step_q  <= '0;
        pend_q  <= 8'd0;
        seg_q   <= {DIGITS{SEG_ZERO}};
      end else begin
        combo_q <= combo_d;
        mult_q  <= mult_d;
        step_q  <= step_d;
        pend_q  <= pend_d;
        seg_q   <= seg_d;
      end
    end

    bcd_counter_sat #(.DIGITS(DIGITS)) u_score (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (clear_i),
      .inc_i    (drain),
      .bcd_o    (bcd),
      .at_max_o (at_max)
    );

    assign score_bcd_o[p*DIGITS*4 +: DIGITS*4] = bcd;
    assign seg_out_o[p*DIGITS*7 +: DIGITS*7]   = seg_q;
    assign combo_o[p*8 +: 8]                   = combo_q;
    assign mult_o[p*3 +: 3]                    = mult_q;
    assign busy_o[p]                           = (pend_q != 8'd0);
    assign saturated_o[p]                      = at_max;
  end

endmodule

// File: tb/tb_dance_score_engine.sv
// Directed bench for dance_score_engine with two players and two digits.
// Latency: checks sample on the falling edge, half a cycle after the active edge.
// Backpressure: every wait for the drain to finish is bounded by a cycle budget.
module tb_dance_score_engine;

  localparam int NP = 2;
  localparam int DG = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              game_active_i;
  logic              clear_i;
  logic [NP-1:0]     hit_perfect_i, hit_good_i, hit_miss_i;
  logic [NP*DG*4-1:0] score_bcd_o;
  logic [NP*DG*7-1:0] seg_out_o;
  logic [NP*8-1:0]   combo_o;
  logic [NP*3-1:0]   mult_o;
  logic [NP-1:0]     busy_o, saturated_o;

  int errors = 0;
  int checks = 0;

  localparam logic [27:0] SEG_ALL0 = {4{7'b1000000}};

  always #5 clock = ~clock;

  dance_score_engine #(
    .N_PLAYERS(NP), .DIGITS(DG), .PERFECT_PTS(3), .GOOD_PTS(1), .COMBO_STEP(10), .MAX_MULT(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .game_active_i (game_active_i),
    .clear_i       (clear_i),
    .hit_perfect_i (hit_perfect_i),
    .hit_good_i    (hit_good_i),
    .hit_miss_i    (hit_miss_i),
    .score_bcd_o   (score_bcd_o),
    .seg_out_o     (seg_out_o),
    .combo_o       (combo_o),
    .mult_o        (mult_o),
    .busy_o        (busy_o),
    .saturated_o   (saturated_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle level pulse: 0=good 1=perfect 2=miss 3=perfect+miss
  task automatic pulse(input int kind, input int p);
    if (kind == 0) hit_good_i[p] = 1'b1;
    if (kind == 1 || kind == 3) hit_perfect_i[p] = 1'b1;
    if (kind == 2 || kind == 3) hit_miss_i[p] = 1'b1;
    @(negedge clock);
    hit_good_i[p] = 1'b0; hit_perfect_i[p] = 1'b0; hit_miss_i[p] = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o != '0 && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (busy_o != '0) begin
      errors++;
      checks++;
      $error("FAIL %s timeout busy=%b required=00", tag, busy_o);
    end
    @(negedge clock);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(negedge clock);
    clear_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; game_active_i = 1'b0; clear_i = 1'b0;
    hit_perfect_i = '0; hit_good_i = '0; hit_miss_i = '0;
    repeat (3) @(negedge clock);
    chk("rst_score", 32'(score_bcd_o), 32'h0000);
    chk("rst_seg",   32'(seg_out_o), 32'(SEG_ALL0));
    chk("rst_combo", 32'(combo_o), 32'h0000);
    chk("rst_mult",  32'(mult_o), 32'(6'b001_001));
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_sat",   32'(saturated_o), 32'd0);
    reset = 1'b0;
    game_active_i = 1'b1;
    @(negedge clock);

    // Single perfect on player 0 at mult 1: three points, busy three cycles
    hit_perfect_i[0] = 1'b1;
    @(negedge clock);
    hit_perfect_i[0] = 1'b0;
    chk("p_load_busy", 32'(busy_o), 32'b01);
    chk("p_load_score", 32'(score_bcd_o), 32'h0000);
    @(negedge clock);
    chk("p_first_inc", 32'(score_bcd_o), 32'h0001);
    @(negedge clock);
    chk("p_busy_2", 32'(busy_o), 32'b01);
    @(negedge clock);
    chk("p_score", 32'(score_bcd_o), 32'h0003);
    chk("p_busy_done", 32'(busy_o), 32'b00);
    @(negedge clock);
    chk("p_seg", 32'(seg_out_o), 32'({7'b1000000, 7'b1000000, 7'b1000000, 7'b0110000}));
    chk("p_combo", 32'(combo_o), 32'h0001);

    // Ten goods from a clean slate raise the multiplier; the eleventh is worth two
    do_clear();
    @(negedge clock);
    chk("clr_score", 32'(score_bcd_o), 32'h0000);
    for (int i = 0; i < 10; i++) pulse(0, 0);
    wait_idle("g10");
    chk("g10_score", 32'(score_bcd_o), 32'h0010);
    chk("g10_mult",  32'(mult_o), 32'(6'b001_010));
    pulse(0, 0);
    wait_idle("g11");
    chk("g11_score", 32'(score_bcd_o), 32'h0012);
    chk("g11_combo", 32'(combo_o), 32'd11);

    // Combo to 25 (goods 12..20 at x2, 21..25 at x3), then a miss
    for (int i = 0; i < 14; i++) pulse(0, 0);
    wait_idle("g25");
    chk("g25_score", 32'(score_bcd_o), 32'h0045);
    chk("g25_combo", 32'(combo_o), 32'd25);
    chk("g25_mult",  32'(mult_o), 32'(6'b001_011));
    pulse(2, 0);
    wait_idle("miss");
    chk("miss_combo", 32'(combo_o), 32'd0);
    chk("miss_mult",  32'(mult_o), 32'(6'b001_001));
    chk("miss_score", 32'(score_bcd_o), 32'h0045);
    pulse(1, 0);
    wait_idle("after_miss");
    chk("am_score", 32'(score_bcd_o), 32'h0048);

    // Perfect and miss together: miss wins
    pulse(3, 0);
    @(negedge clock);
    chk("pm_busy",  32'(busy_o), 32'b00);
    chk("pm_combo", 32'(combo_o), 32'd0);
    chk("pm_score", 32'(score_bcd_o), 32'h0048);

    // A held-high good counts once
    hit_good_i[0] = 1'b1;
    repeat (6) @(negedge clock);
    hit_good_i[0] = 1'b0;
    wait_idle("held");
    chk("held_score", 32'(score_bcd_o), 32'h0049);
    chk("held_combo", 32'(combo_o), 32'd1);

    // Paused game drops events
    game_active_i = 1'b0;
    pulse(1, 0);
    chk("pause_busy", 32'(busy_o), 32'b00);
    chk("pause_score", 32'(score_bcd_o), 32'h0049);
    game_active_i = 1'b1;

    // Player 1 is independent of player 0
    pulse(1, 1);
    wait_idle("p1");
    chk("p1_score", 32'(score_bcd_o), 32'h0349);
    chk("p1_combo", 32'(combo_o), 32'h0101);

    // Build score 98 at mult 4: one perfect + 29 goods = 62, then 9 goods at x4 = 98
    do_clear();
    pulse(1, 0);
    for (int i = 0; i < 29; i++) pulse(0, 0);
    for (int i = 0; i < 9; i++) pulse(0, 0);
    wait_idle("s98");
    chk("s98_score", 32'(score_bcd_o), 32'h0098);
    chk("s98_mult",  32'(mult_o), 32'(6'b001_100));
    chk("s98_sat",   32'(saturated_o), 32'b00);
    pulse(1, 0);
    wait_idle("s99");
    chk("s99_score", 32'(score_bcd_o), 32'h0099);
    chk("s99_sat",   32'(saturated_o), 32'b01);
    chk("s99_busy",  32'(busy_o), 32'b00);
    pulse(1, 0);
    chk("s99_more_busy", 32'(busy_o), 32'b00);
    chk("s99_seg", 32'(seg_out_o), 32'({7'b1000000, 7'b1000000, 7'b0010000, 7'b0010000}));
    do_clear();
    chk("s_clr_score", 32'(score_bcd_o), 32'h0000);
    chk("s_clr_sat",   32'(saturated_o), 32'b00);
    chk("s_clr_seg",   32'(seg_out_o), 32'(SEG_ALL0));
    chk("s_clr_mult",  32'(mult_o), 32'(6'b001_001));

    // Reset in the middle of a drain takes effect without a clock edge
    pulse(1, 0); pulse(1, 0); pulse(1, 0);
    chk("rd_busy_pre", 32'(busy_o), 32'b01);
    #1 reset = 1'b1;
    #1;
    chk("rd_score", 32'(score_bcd_o), 32'h0000);
    chk("rd_seg",   32'(seg_out_o), 32'(SEG_ALL0));
    chk("rd_combo", 32'(combo_o), 32'h0000);
    chk("rd_mult",  32'(mult_o), 32'(6'b001_001));
    chk("rd_busy",  32'(busy_o), 32'b00);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rd_after", 32'(score_bcd_o), 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
